// File: rtl/new_pe_ctrl_pkg.sv
// Shared types and buffer geometry for the new_pe sequencer.
package pe_ctrl_pkg;

  localparam int BUF_ROWS  = 4;
  localparam int BUF_TAPS  = 16;
  localparam int OUT_GROUP = 4;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_LD_FILT = 4'd1,
    ST_LD_WIN  = 4'd2,
    ST_CLR     = 4'd3,
    ST_MAC     = 4'd4,
    ST_DRAIN   = 4'd5,
    ST_SHIFT   = 4'd6,
    ST_FLUSH   = 4'd7,
    ST_DONE    = 4'd8
  } pe_ctrl_state_t;

endpackage

// File: rtl/new_pe_ctrl_wrap_counter.sv
// Free-running wrap-around counter with enable, synchronous clear and
// an all-ones terminal-count flag.
module wrap_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  output logic [WIDTH-1:0] count,
  output logic             tc
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + WIDTH'(1);
    end
  end

  assign tc = &count;

endmodule

// File: rtl/new_pe_ctrl.sv
// Job sequencer for new_pe: filter/window loads, 16-tap MAC sweep,
// output shift register pushes and group-ready flagging.
module new_pe_ctrl
  import pe_ctrl_pkg::*;
#(
  parameter int KERNEL_COUNT = 4,
  parameter int KW = (KERNEL_COUNT > 1) ? $clog2(KERNEL_COUNT) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     load_filters,
  input  logic [7:0]               num_windows,
  input  logic                     filt_valid,
  input  logic                     win_valid,
  output logic                     busy,
  output logic                     done,
  output logic                     filt_req,
  output logic [KW-1:0]            filt_kernel,
  output logic                     win_req,
  output logic [0:KERNEL_COUNT-1]  filter_wr_en,
  output logic [1:0]               wr_index_filter_buff,
  output logic                     window_wr_en,
  output logic [1:0]               wr_index_window,
  output logic [3:0]               rd_index,
  output logic                     mac_en,
  output logic                     mac_clr,
  output logic                     shift_reg_en,
  output logic                     out_valid,
  output logic [2:0]               out_count
);

  localparam int FW = KW + 2;
  localparam logic [FW-1:0] FILT_LAST = FW'(BUF_ROWS * KERNEL_COUNT - 1);
  localparam bit FILT_POW2 = ((BUF_ROWS * KERNEL_COUNT) == (1 << FW));

  pe_ctrl_state_t state_q, state_d;
  logic [7:0]     nw_q;
  logic           full_q;

  logic [FW-1:0]  filt_cnt;
  logic [1:0]     row_cnt;
  logic [3:0]     tap_cnt;
  logic [7:0]     win_cnt;
  logic [1:0]     grp_cnt;
  logic           filt_tc, row_tc, tap_tc, win_tc, grp_tc;
  logic           filt_acc, win_acc, filt_last, win_last, job_end;

  // Handshake: a row moves only in a cycle where req and valid are both high;
  // valid without req is ignored and a low valid simply holds the counters.
  assign filt_acc = (state_q == ST_LD_FILT) && filt_valid;
  assign win_acc  = (state_q == ST_LD_WIN) && win_valid;
  assign job_end  = (state_q == ST_DONE);

  assign filt_last = FILT_POW2 ? filt_tc : (filt_cnt == FILT_LAST);
  // Checked before the increment so 255 windows never sees the 8-bit wrap.
  assign win_last  = win_tc ? (nw_q == 8'hFF) : ((win_cnt + 8'd1) == nw_q);

  wrap_counter #(.WIDTH(FW)) u_filt_cnt (
    .clk(clk), .rst(rst), .en(filt_acc), .clr(job_end || (filt_acc && filt_last)),
    .count(filt_cnt), .tc(filt_tc)
  );

  wrap_counter #(.WIDTH(2)) u_row_cnt (
    .clk(clk), .rst(rst), .en(win_acc), .clr(job_end),
    .count(row_cnt), .tc(row_tc)
  );

  wrap_counter #(.WIDTH(4)) u_tap_cnt (
    .clk(clk), .rst(rst), .en(state_q == ST_MAC), .clr(job_end),
    .count(tap_cnt), .tc(tap_tc)
  );

  wrap_counter #(.WIDTH(8)) u_win_cnt (
    .clk(clk), .rst(rst), .en(state_q == ST_SHIFT), .clr(job_end),
    .count(win_cnt), .tc(win_tc)
  );

  wrap_counter #(.WIDTH(2)) u_grp_cnt (
    .clk(clk), .rst(rst), .en(state_q == ST_SHIFT), .clr(job_end),
    .count(grp_cnt), .tc(grp_tc)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (num_windows == 8'd0)  state_d = ST_DONE;
          else if (load_filters)    state_d = ST_LD_FILT;
          else                      state_d = ST_LD_WIN;
        end
      end
      ST_LD_FILT: if (filt_acc && filt_last) state_d = ST_LD_WIN;
      ST_LD_WIN:  if (win_acc && row_tc)     state_d = ST_CLR;
      ST_CLR:     state_d = ST_MAC;
      ST_MAC:     if (tap_tc)                state_d = ST_DRAIN;
      ST_DRAIN:   state_d = ST_SHIFT;
      ST_SHIFT: begin
        // grp_tc here means the group counter is about to wrap to 0.
        if (win_last) state_d = grp_tc ? ST_DONE : ST_FLUSH;
        else          state_d = ST_LD_WIN;
      end
      ST_FLUSH:   state_d = ST_DONE;
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      nw_q    <= 8'd0;
      full_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      full_q  <= (state_q == ST_SHIFT) && grp_tc;
      if (state_q == ST_IDLE && start) nw_q <= num_windows;
    end
  end

  always_comb begin
    filter_wr_en = '0;
    for (int k = 0; k < KERNEL_COUNT; k++) begin
      if (filt_acc && (filt_cnt[FW-1:2] == KW'(k))) filter_wr_en[k] = 1'b1;
    end
  end

  assign busy                 = (state_q != ST_IDLE);
  assign done                 = job_end;
  assign filt_req             = (state_q == ST_LD_FILT);
  assign filt_kernel          = filt_req ? filt_cnt[FW-1:2] : '0;
  assign wr_index_filter_buff = filt_req ? filt_cnt[1:0] : 2'd0;
  assign win_req              = (state_q == ST_LD_WIN);
  assign window_wr_en         = win_acc;
  assign wr_index_window      = win_req ? row_cnt : 2'd0;
  assign mac_en               = (state_q == ST_MAC);
  assign rd_index             = mac_en ? tap_cnt : 4'd0;
  assign mac_clr              = (state_q == ST_CLR);
  assign shift_reg_en         = (state_q == ST_SHIFT);
  assign out_valid            = full_q || (state_q == ST_FLUSH);
  assign out_count            = full_q ? 3'(OUT_GROUP)
                              : (state_q == ST_FLUSH) ? {1'b0, grp_cnt} : 3'd0;

endmodule

// File: tb/tb_new_pe_ctrl.sv
// Self-checking bench for new_pe_ctrl: job-level reference model with
// expected-event queues, randomized valid stalls and job parameters.
module tb_new_pe_ctrl;

  localparam int K  = 4;
  localparam int KW = 2;

  logic           clk, rst, start, load_filters, filt_valid, win_valid;
  logic [7:0]     num_windows;
  logic           busy, done, filt_req, win_req, window_wr_en;
  logic [KW-1:0]  filt_kernel;
  logic [0:K-1]   filter_wr_en;
  logic [1:0]     wr_index_filter_buff, wr_index_window;
  logic [3:0]     rd_index;
  logic           mac_en, mac_clr, shift_reg_en, out_valid;
  logic [2:0]     out_count;

  new_pe_ctrl #(.KERNEL_COUNT(K)) dut (
    .clk(clk), .rst(rst), .start(start), .load_filters(load_filters),
    .num_windows(num_windows), .filt_valid(filt_valid), .win_valid(win_valid),
    .busy(busy), .done(done), .filt_req(filt_req), .filt_kernel(filt_kernel),
    .win_req(win_req), .filter_wr_en(filter_wr_en),
    .wr_index_filter_buff(wr_index_filter_buff), .window_wr_en(window_wr_en),
    .wr_index_window(wr_index_window), .rd_index(rd_index), .mac_en(mac_en),
    .mac_clr(mac_clr), .shift_reg_en(shift_reg_en), .out_valid(out_valid),
    .out_count(out_count)
  );

  logic [25:0] outs_vec;
  assign outs_vec = {busy, done, filt_req, filt_kernel, win_req, filter_wr_en,
                     wr_index_filter_buff, window_wr_en, wr_index_window, rd_index,
                     mac_en, mac_clr, shift_reg_en, out_valid, out_count};

  // Clock and cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard state
  logic [7:0] exp_filt_q[$];
  logic [7:0] exp_win_q[$];
  logic [7:0] exp_tap_q[$];
  logic [7:0] exp_out_q[$];
  int n_checks = 0, n_errors = 0;
  int done_cnt, shift_cnt, clr_cnt, freq_cnt, en_cnt, done_cyc, start_cyc;
  int hs_err = 0, idle_err = 0, ovl_err = 0;
  int vmode = 0;
  bit mon_en = 1'b0;
  int cur_nw;
  bit cur_load;
  int mon_fk;
  logic [7:0] mon_e;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Valid drivers: 0 = always high, 1 = win_valid toggles, 2 = random stalls
  always @(posedge clk) begin
    #1;
    case (vmode)
      1:       begin filt_valid = 1'b1; win_valid = ~win_valid; end
      2:       begin filt_valid = 1'($urandom_range(0, 1)); win_valid = 1'($urandom_range(0, 1)); end
      default: begin filt_valid = 1'b1; win_valid = 1'b1; end
    endcase
  end

  // Monitor: pops expected events as the DUT produces them
  always @(negedge clk) begin
    if (mon_en) begin
      if (|filter_wr_en) begin
        mon_fk = 0;
        for (int k = 0; k < K; k++) if (filter_wr_en[k]) mon_fk = k;
        if (exp_filt_q.size() == 0) check("filt_extra", 1, 0);
        else begin
          mon_e = exp_filt_q.pop_front();
          check("filt_row", mon_fk * 4 + int'(wr_index_filter_buff), mon_e);
          check("filt_kernel", filt_kernel, mon_e[7:2]);
          check("filt_onehot", $countones(filter_wr_en), 1);
        end
      end
      if (window_wr_en) begin
        if (exp_win_q.size() == 0) check("win_extra", 1, 0);
        else check("win_row", wr_index_window, exp_win_q.pop_front());
      end
      if (mac_en) begin
        if (exp_tap_q.size() == 0) check("tap_extra", 1, 0);
        else check("rd_index", rd_index, exp_tap_q.pop_front());
      end
      if (out_valid) begin
        if (exp_out_q.size() == 0) check("out_extra", 1, 0);
        else check("out_count", out_count, exp_out_q.pop_front());
      end
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (shift_reg_en) shift_cnt++;
      if (mac_clr) clr_cnt++;
      if (filt_req) freq_cnt++;
      if (mac_en || mac_clr || shift_reg_en || window_wr_en || (|filter_wr_en) ||
          filt_req || win_req || out_valid) en_cnt++;
      if (window_wr_en !== (win_req && win_valid)) hs_err++;
      if ((|filter_wr_en) !== (filt_req && filt_valid)) hs_err++;
      if (!mac_en && rd_index != 4'd0) idle_err++;
      if (!win_req && wr_index_window != 2'd0) idle_err++;
      if (!filt_req && (filt_kernel != '0 || wr_index_filter_buff != 2'd0)) idle_err++;
      if (!busy && (mac_en || mac_clr || shift_reg_en || win_req || filt_req)) idle_err++;
      if (out_valid && shift_reg_en) ovl_err++;
    end
  end

  // Reference model: a job is a filter sweep, nw windows of 4 rows + 16 taps,
  // one output per window grouped by four, and a flush of any partial group.
  task automatic start_job(input bit load, input int nw);
    cur_load = load;
    cur_nw = nw;
    exp_filt_q.delete(); exp_win_q.delete(); exp_tap_q.delete(); exp_out_q.delete();
    if (load && nw != 0)
      for (int i = 0; i < 4 * K; i++) exp_filt_q.push_back(8'(i));
    for (int w = 1; w <= nw; w++) begin
      for (int r = 0; r < 4; r++) exp_win_q.push_back(8'(r));
      for (int t = 0; t < 16; t++) exp_tap_q.push_back(8'(t));
      if (w % 4 == 0) exp_out_q.push_back(8'd4);
    end
    if (nw % 4 != 0) exp_out_q.push_back(8'(nw % 4));
    done_cnt = 0; shift_cnt = 0; clr_cnt = 0; freq_cnt = 0; en_cnt = 0; done_cyc = 0;
    @(posedge clk); #1;
    load_filters = load; num_windows = 8'(nw); start = 1'b1; start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int n = 0;
    while (done_cnt == 0 && n < limit) begin @(posedge clk); n++; end
    check("done_timeout", (done_cnt != 0), 1);
  endtask

  task automatic finish_job();
    int exp_lat;
    repeat (3) @(posedge clk);
    exp_lat = (cur_load && cur_nw != 0 ? 4 * K : 0) + 23 * cur_nw +
              (cur_nw % 4 != 0 ? 1 : 0) + 1;
    check("done_count", done_cnt, 1);
    if (vmode == 0) check("done_latency", done_cyc - start_cyc, exp_lat);
    check("shift_count", shift_cnt, cur_nw);
    check("clr_count", clr_cnt, cur_nw);
    check("filt_left", exp_filt_q.size(), 0);
    check("win_left", exp_win_q.size(), 0);
    check("tap_left", exp_tap_q.size(), 0);
    check("out_left", exp_out_q.size(), 0);
    if (!cur_load) check("filt_req_cycles", freq_cnt, 0);
    if (cur_nw == 0) check("nw0_enables", en_cnt, 0);
    check("handshake", hs_err, 0);
    check("idle_outputs", idle_err, 0);
    check("out_vs_shift", ovl_err, 0);
  endtask

  task automatic run_job(input bit load, input int nw, input int mode);
    vmode = mode;
    start_job(load, nw);
    wait_done(60 * (nw + 1) + 200);
    finish_job();
  endtask

  initial begin
    int n;
    bit seen;
    rst = 1'b1; start = 1'b0; load_filters = 1'b0; num_windows = 8'd0;
    filt_valid = 1'b0; win_valid = 1'b0;
    @(negedge clk);
    check("reset_outputs", outs_vec, 0);
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0; mon_en = 1'b1;

    run_job(1'b1, 1, 0);
    run_job(1'b0, 8, 0);
    run_job(1'b0, 6, 1);
    run_job(1'b1, 0, 0);
    run_job(1'b0, 255, 0);

    // Reset in the middle of the MAC sweep
    vmode = 0;
    start_job(1'b0, 3);
    n = 0;
    while (rd_index != 4'd7 && n < 200) begin @(negedge clk); n++; end
    check("reach_tap7", rd_index, 7);
    mon_en = 1'b0;
    rst = 1'b1;
    #1;
    check("rst_mid_outputs", outs_vec, 0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    seen = 1'b0;
    repeat (6) begin @(negedge clk); seen |= (done || out_valid || busy); end
    check("rst_quiet", seen, 0);
    mon_en = 1'b1;
    run_job(1'b1, 5, 0);

    // start while busy must be ignored, latched parameters kept
    fork
      run_job(1'b0, 6, 0);
      begin
        repeat (30) @(posedge clk);
        #1; start = 1'b1; num_windows = 8'd2; load_filters = 1'b1;
        @(posedge clk); #1; start = 1'b0;
      end
    join
    num_windows = 8'd0; load_filters = 1'b0;

    for (int j = 0; j < 4; j++)
      run_job(1'($urandom_range(0, 1)), $urandom_range(1, 13), $urandom_range(0, 2));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
